// File: rtl/bus_port.sv
// bus_port: per-processor bus endpoint with a credit-throttled TX request FIFO and a counted RX delivery stream
module bus_port #(
    parameter  int NUM_PROC        = 4,
    parameter  int PORT_ID         = 0,
    parameter  int TX_DEPTH        = 4,
    parameter  int MAX_OUTSTANDING = 2,
    parameter  int RX_DEPTH        = 4,
    localparam int DEST_W          = $clog2(NUM_PROC) + 1,
    localparam int CNT_W           = $clog2(RX_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              i_tx_valid,
    input  logic [DEST_W-1:0] i_tx_dest,
    output logic              o_tx_ready,
    output logic              o_bus_request,
    output logic [DEST_W-1:0] o_bus_request_dest,
    input  logic              i_bus_credit,
    input  logic              i_bus_avail,
    output logic              o_rx_valid,
    input  logic              i_rx_ready,
    output logic [CNT_W-1:0]  o_rx_count,
    output logic              o_tx_err,
    output logic              o_proto_err
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int OW = $clog2(TX_DEPTH + 1);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {TX_IDLE, TX_ISSUE, TX_STALL} tx_state_t;

    tx_state_t         r_state;
    logic [DEST_W-1:0] r_mem [TX_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [OW-1:0]     r_occ;
    logic [CW-1:0]     r_out;
    logic              r_avail_q;
    logic [CNT_W-1:0]  r_rx_count;
    logic [OW-1:0]     w_occ_nxt;
    logic [CW-1:0]     w_out_nxt;
    logic              w_accept;
    logic              w_legal;
    logic              w_push;
    logic              w_issue;
    logic              w_credit_err;
    logic              w_deliver;
    logic              w_consume;
    logic              w_rx_full;

    assign o_tx_ready   = r_occ < OW'(TX_DEPTH);
    assign w_legal      = (i_tx_dest < DEST_W'(NUM_PROC)) && (i_tx_dest != DEST_W'(PORT_ID));
    assign w_accept     = i_tx_valid && o_tx_ready;
    assign w_push       = w_accept && w_legal;
    // a credit arriving while stalled frees a slot for an issue at the same edge
    assign w_issue      = (r_state == TX_ISSUE) || ((r_state == TX_STALL) && i_bus_credit);
    assign w_credit_err = i_bus_credit && !w_issue && (r_out == '0);
    assign o_rx_valid   = r_rx_count != '0;
    assign o_rx_count   = r_rx_count;
    assign w_deliver    = i_bus_avail && !r_avail_q;
    assign w_consume    = o_rx_valid && i_rx_ready;
    assign w_rx_full    = r_rx_count == CNT_W'(RX_DEPTH);

    // next occupancy and outstanding count, used both for state update and state selection
    always_comb begin
        w_occ_nxt = r_occ + OW'(w_push) - OW'(w_issue);
        w_out_nxt = (w_issue && !i_bus_credit) ? r_out + 1'b1 :
                    (i_bus_credit && !w_issue && r_out != '0) ? r_out - 1'b1 : r_out;
    end

    // TX FIFO storage; contents are don't-care while the pointers mark it empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_tx_dest;
    end

    // TX FSM: pointers, credit accounting, registered request pulse and tx error flag
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state            <= TX_IDLE;
            r_wr_ptr           <= '0;
            r_rd_ptr           <= '0;
            r_occ              <= '0;
            r_out              <= '0;
            o_bus_request      <= 1'b0;
            o_bus_request_dest <= '0;
            o_tx_err           <= 1'b0;
        end else begin
            r_wr_ptr           <= r_wr_ptr + PW'(w_push);
            r_rd_ptr           <= r_rd_ptr + PW'(w_issue);
            r_occ              <= w_occ_nxt;
            r_out              <= w_out_nxt;
            o_bus_request      <= w_issue;
            o_bus_request_dest <= w_issue ? r_mem[r_rd_ptr] : '0;
            o_tx_err           <= o_tx_err || (w_accept && !w_legal);
            r_state            <= (w_occ_nxt == '0) ? TX_IDLE :
                                  (w_out_nxt < CW'(MAX_OUTSTANDING)) ? TX_ISSUE : TX_STALL;
        end
    end

    // RX: count bus_avail rising edges, drain on handshake, flag lost deliveries and stray credits
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_avail_q   <= 1'b0;
            r_rx_count  <= '0;
            o_proto_err <= 1'b0;
        end else begin
            r_avail_q   <= i_bus_avail;
            r_rx_count  <= (w_deliver && !w_consume && !w_rx_full) ? r_rx_count + 1'b1 :
                           (w_consume && !w_deliver) ? r_rx_count - 1'b1 : r_rx_count;
            o_proto_err <= o_proto_err || w_credit_err || (w_deliver && !w_consume && w_rx_full);
        end
    end
endmodule
